// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO master that serialises one read or write frame per request
// and returns read data with an acknowledge-error flag.
module mdio_master #(
    parameter int PRE_LEN = 32,
    parameter int GAP     = 2
) (
    input  logic        mdc,
    input  logic        rst_n,
    input  logic [4:0]  phy_add,
    input  logic [4:0]  reg_add,
    input  logic [15:0] wr_data,
    input  logic        wren,
    input  logic        rden,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_err
);
    localparam int MX = (PRE_LEN > GAP) ? ((PRE_LEN > 16) ? PRE_LEN : 16) : ((GAP > 16) ? GAP : 16);
    localparam int CW = $clog2(MX);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_STOP, S_ADDR, S_TA, S_DATA, S_GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   frame;
    logic [15:0]   sh;
    logic          is_rd, err, last, accept, drive;

    assign last   = cnt == '0;
    // the last GAP edge doubles as an accept edge so held requests repeat every N+GAP cycles
    assign accept = (state == S_IDLE || (state == S_GAP && last)) && (wren || rden);

    always_comb begin
        state_n = state;
        cnt_n   = cnt - CW'(1);
        if (accept) begin
            state_n = S_PRE;
            cnt_n   = CW'(PRE_LEN - 1);
        end else if (state == S_IDLE) begin
            cnt_n = cnt;
        end else if (last) begin
            unique case (state)
                S_PRE:   begin state_n = S_STOP; cnt_n = CW'(3);       end
                S_STOP:  begin state_n = S_ADDR; cnt_n = CW'(9);       end
                S_ADDR:  begin state_n = S_TA;   cnt_n = CW'(1);       end
                S_TA:    begin state_n = S_DATA; cnt_n = CW'(15);      end
                S_DATA:  begin state_n = S_GAP;  cnt_n = CW'(GAP - 1); end
                default: begin state_n = S_IDLE; cnt_n = '0;           end
            endcase
        end
    end

    always_ff @(posedge mdc) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            frame   <= '0;
            sh      <= '0;
            is_rd   <= 1'b0;
            err     <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                frame <= {2'b01, wren ? 2'b01 : 2'b10, phy_add, reg_add, 2'b10, wr_data};
                is_rd <= !wren;
                err   <= 1'b0;
            end else if (state inside {S_STOP, S_ADDR, S_TA, S_DATA}) begin
                frame <= {frame[30:0], 1'b0};
            end
            if (state == S_TA && last)
                err <= mdio_i;
            if (state == S_DATA)
                sh <= {sh[14:0], mdio_i};
            if (state == S_DATA && last && is_rd) begin
                rd_data <= {sh[14:0], mdio_i};
                rd_err  <= err;
            end
        end
    end

    assign drive    = (state inside {S_PRE, S_STOP, S_ADDR}) || (!is_rd && (state inside {S_TA, S_DATA}));
    assign mdio_oe  = drive;
    assign mdio_o   = !drive || state == S_PRE || frame[31];
    assign busy     = state != S_IDLE;
    assign done     = state == S_GAP && cnt == CW'(GAP - 1);
    assign rd_valid = done && is_rd;
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: table, random and corner-sequence checks of mdio_master against a
// bit-level frame model built from the MDIO frame format.
module tb_mdio_master;
    localparam int P = 32;
    localparam int G = 2;
    localparam int N = P + 32;

    logic        mdc = 0, rst_n = 0;
    logic [4:0]  phy_add = 0, reg_add = 0;
    logic [15:0] wr_data = 0;
    logic        wren = 0, rden = 0, mdio_i = 1;
    logic        mdio_o, mdio_oe, busy, done, rd_valid, rd_err;
    logic [15:0] rd_data;

    int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0;
    logic [15:0] exp_rd = 16'h0000;
    logic        exp_err = 1'b0;

    mdio_master #(.PRE_LEN(P), .GAP(G)) dut (
        .mdc(mdc), .rst_n(rst_n), .phy_add(phy_add), .reg_add(reg_add), .wr_data(wr_data),
        .wren(wren), .rden(rden), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
    );

    always #5 mdc = ~mdc;
    always @(posedge mdc) cyc <= cyc + 1;

    typedef struct {
        logic        wr, rd;
        logic [4:0]  pa, ra;
        logic [15:0] wd, pd;
        logic        ta2;
        logic [15:0] exp_data;
        logic        exp_e;
    } vec_t;

    task automatic tick();
        @(posedge mdc);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, req);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_oe"}, mdio_oe, 0);
        chk({tag, "_o"}, mdio_o, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdv"}, rd_valid, 0);
    endtask

    // Caller sits in the cycle before the accept edge; returns in the last GAP cycle.
    task automatic run_frame(input logic wr, input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input logic [15:0] pd, input logic ta2, input logic hold);
        logic [31:0] hdr;
        logic        r, eo, eb;
        r   = !wr;
        hdr = {2'b01, r ? 2'b10 : 2'b01, pa, ra, 2'b10, wd};
        phy_add = pa; reg_add = ra; wr_data = wd; wren = wr; rden = rd;
        tick();
        acc_cyc = cyc;
        if (!hold) begin wren = 0; rden = 0; end
        for (int k = 0; k < N; k++) begin
            eo = !(r && k >= P + 14);
            eb = (k < P || !eo) ? 1'b1 : hdr[31 - (k - P)];
            chk("mdio_o", mdio_o, eb);
            chk("mdio_oe", mdio_oe, eo);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            mdio_i = !r ? 1'b1 : (k == P + 15) ? ta2 : (k >= P + 16) ? pd[15 - (k - P - 16)] : 1'b1;
            tick();
        end
        mdio_i = 1;
        if (r) begin exp_rd = pd; exp_err = ta2; end
        chk("done", done, 1);
        chk("rd_valid", rd_valid, r);
        chk("rd_data", rd_data, exp_rd);
        chk("rd_err", rd_err, exp_err);
        chk("gap_oe", mdio_oe, 0);
        chk("gap_busy", busy, 1);
        for (int g = 1; g < G; g++) begin
            tick();
            chk("gap_done", done, 0);
            chk("gap_rdv", rd_valid, 0);
            chk("gap_oe", mdio_oe, 0);
            chk("gap_busy", busy, 1);
        end
    endtask

    vec_t tbl[5];
    int   prev;

    initial begin
        tbl[0] = '{1, 0, 5'h00, 5'h00, 16'h1140, 16'h0000, 0, 16'h0000, 0};
        tbl[1] = '{0, 1, 5'h00, 5'h01, 16'h0000, 16'h796D, 0, 16'h796D, 0};
        tbl[2] = '{0, 1, 5'h03, 5'h02, 16'h0000, 16'hFFFF, 1, 16'hFFFF, 1};
        tbl[3] = '{1, 0, 5'h1F, 5'h1F, 16'hA5A5, 16'h0000, 0, 16'hFFFF, 1};
        tbl[4] = '{0, 1, 5'h11, 5'h0A, 16'h0000, 16'h0001, 0, 16'h0001, 0};

        repeat (3) tick();
        chk_idle("reset");
        chk("reset_rd_data", rd_data, 0);
        chk("reset_rd_err", rd_err, 0);
        rst_n = 1;
        tick();
        chk_idle("post_reset");

        foreach (tbl[i]) begin
            run_frame(tbl[i].wr, tbl[i].rd, tbl[i].pa, tbl[i].ra, tbl[i].wd, tbl[i].pd, tbl[i].ta2, 0);
            chk("tbl_rd_data", rd_data, tbl[i].exp_data);
            chk("tbl_rd_err", rd_err, tbl[i].exp_e);
            tick();
            chk_idle("tbl_idle");
        end

        for (int i = 0; i < 20; i++) begin
            logic w;
            w = $urandom_range(0, 1);
            run_frame(w, !w, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                      ($urandom_range(0, 3) == 0), 0);
            tick();
            chk_idle("rand_idle");
        end

        // held write request repeats with exactly G idle cycles between frames
        for (int f = 0; f < 3; f++) begin
            prev = acc_cyc;
            run_frame(1, 0, 5'h07, 5'h09, 16'hC3C3, 16'h0000, 0, f < 2);
            if (f > 0) chk("held_spacing", acc_cyc - prev, N + G);
        end
        tick();
        chk_idle("held_end");

        // simultaneous requests: the write wins and no read follows
        run_frame(1, 1, 5'h02, 5'h04, 16'h0F0F, 16'h0000, 0, 0);
        repeat (2) begin tick(); chk_idle("both_idle"); end

        // reset during bit 40 of a read abandons the frame
        phy_add = 5'h01; reg_add = 5'h01; rden = 1;
        tick();
        rden = 0;
        repeat (40) tick();
        chk("mid_busy", busy, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk_idle("mid_reset");
        repeat (3) begin tick(); chk_idle("mid_after"); end
        run_frame(0, 1, 5'h01, 5'h01, 16'h0000, 16'h2468, 0, 0);
        tick();
        chk_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
